// File: rtl/hist_dump_receiver.sv
// Histogram dump sink: stages each 32-beat frame, checks framing, commits good frames into
// saturating accumulators with a registered read port. Define HIST_PEAK_EN to build the peak tracker.
module hist_dump_receiver #(
    parameter int unsigned NBINS  = 32,
    parameter int unsigned ACC_W  = 8,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              bin_reset,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [4:0]        rd_addr,
    output logic [ACC_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              frame_done,
    output logic              frame_err,
    output logic              acc_sat,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [4:0]        peak_bin,
    output logic [ACC_W-1:0]  peak_val
);

    localparam int unsigned IDX_W = $clog2(NBINS);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NBINS - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCommit, StDrop} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        stage_q [NBINS];
    logic [ACC_W-1:0]  acc_q   [NBINS];
    logic [ACC_W-1:0]  acc_d   [NBINS];
    logic [FCNT_W-1:0] cnt_q;
    logic              err_q, sat_q;
    logic [ACC_W-1:0]  rd_data_q;
    logic              rd_valid_q;
    logic              stage_we, err_set, commit, beat_bad, sat_any;

    // idx_q is held at 0 in StIdle/StCommit/StDrop, so a fresh frame always lands at bin 0.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stage_we = 1'b0;
        err_set  = 1'b0;
        commit   = 1'b0;
        beat_bad = (s_data[7:4] != 4'h0) || (s_last != (idx_q == LastIdx));
        unique case (state_q)
            StIdle, StRecv, StCommit: begin
                if (state_q == StCommit) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end
                if (s_valid) begin
                    stage_we = 1'b1;
                    if (beat_bad) begin
                        err_set = 1'b1;
                        state_d = s_last ? StIdle : StDrop;
                        idx_d   = '0;
                    end else if (s_last) begin
                        state_d = StCommit;
                        idx_d   = '0;
                    end else begin
                        state_d = StRecv;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            StDrop: begin
                if (s_valid && s_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // clr wins over a commit in the same cycle.
    always_comb begin
        logic [ACC_W:0]   sum;
        logic [ACC_W-1:0] clipped;
        sat_any = 1'b0;
        for (int i = 0; i < NBINS; i++) begin
            sum     = {1'b0, acc_q[i]} + {{(ACC_W - 3){1'b0}}, stage_q[i]};
            clipped = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            sat_any = sat_any | sum[ACC_W];
            if (clr) begin
                acc_d[i] = '0;
            end else if (commit) begin
                acc_d[i] = clipped;
            end else begin
                acc_d[i] = acc_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge bin_reset) begin
        if (bin_reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NBINS; i++) begin
                stage_q[i] <= '0;
                acc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= acc_q[rd_addr];
            end
            if (stage_we) begin
                stage_q[idx_q] <= s_data[3:0];
            end
            for (int i = 0; i < NBINS; i++) begin
                acc_q[i] <= acc_d[i];
            end
            if (clr) begin
                cnt_q <= '0;
                sat_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                if (commit) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (sat_any) begin
                        sat_q <= 1'b1;
                    end
                end
                if (err_set) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign frame_done = commit && !clr;
    assign frame_err  = err_q;
    assign acc_sat    = sat_q;
    assign frame_cnt  = cnt_q;

`ifdef HIST_PEAK_EN
    logic [4:0]       pk_bin_q, pk_bin_d;
    logic [ACC_W-1:0] pk_val_q, pk_val_d;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        pk_bin_d = '0;
        pk_val_d = acc_d[0];
        for (int i = 1; i < NBINS; i++) begin
            if (acc_d[i] > pk_val_d) begin
                pk_val_d = acc_d[i];
                pk_bin_d = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge bin_reset) begin
        if (bin_reset) begin
            pk_bin_q <= '0;
            pk_val_q <= '0;
        end else if (clr || commit) begin
            pk_bin_q <= pk_bin_d;
            pk_val_q <= pk_val_d;
        end
    end

    assign peak_bin = pk_bin_q;
    assign peak_val = pk_val_q;
`else
    assign peak_bin = '0;
    assign peak_val = '0;
`endif

endmodule
